msrv32_store_unit: RTL and testbench
====================================

Name: msrv32_store_unit

Overview:
- Sequential store path of the RV32I core; the write-side counterpart of the load/write-back path.
- Takes the store request from the execute stage (effective address from the immediate adder, rs2 data, funct3). It produces byte-lane-aligned write data and a byte mask, then runs a req/ack handshake with the data-memory port.
- Flags misaligned or illegal stores instead of issuing them, and reports completion so the pipeline can stall on busy_out.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32; 4 byte lanes)
- TIMEOUT_CYCLES, 16, max cycles waiting for ack (used only with the optional feature)

Ports:
- ms_riscv32_mp_clk_in  input  1  clock
- ms_riscv32_mp_rst_in  input  1  synchronous reset, active-high
- store_req_in  input  1  execute stage requests a store (single-cycle strobe)
- funct3_in  input  3  store width: 000 SB, 001 SH, 010 SW, others illegal
- iadder_in  input  32  effective byte address
- rs2_in  input  32  store source data
- dm_ack_in  input  1  memory accepted the write
- dm_wr_req_out  output  1  write request to memory
- dm_addr_out  output  32  word-aligned address {addr[31:2],2'b00}
- dm_data_out  output  32  lane-replicated write data
- dm_wr_mask_out  output  4  byte enable
- busy_out  output  1  store in flight; stall pipeline
- done_out  output  1  one-cycle pulse on completion
- misaligned_out  output  1  one-cycle pulse: misaligned or illegal funct3, store dropped
- timeout_out  output  1  one-cycle pulse on ack timeout

Behaviour:
- Reset: state IDLE; all outputs 0 (addr, data, mask included); counter 0.
- Reset asserted mid-transaction: state returns to IDLE and dm_wr_req_out drops the next edge. No done_out pulse.
- FSM IDLE, REQ.
- IDLE, store_req_in=1, legal and aligned: latch addr/data/mask and go to REQ. dm_wr_req_out and busy_out are high from cycle N+1.
- IDLE, store_req_in=1, misaligned or illegal: stay in IDLE. misaligned_out pulses at N+1; no memory request.
- REQ: hold addr/data/mask stable. When dm_ack_in is sampled high at edge M, go to IDLE; at M+1 dm_wr_req_out=0, busy_out=0, done_out=1 for one cycle.
- store_req_in while in REQ: ignored; the caller must honour busy_out.
- Ack in IDLE: ignored.
- Back-to-back: a new request is accepted in the cycle done_out is high (state is IDLE).
- Lane rules, a = iadder_in[1:0]:
  - SB: data = {4{rs2[7:0]}}, mask = 4'b0001 << a; never misaligned.
  - SH: data = {2{rs2[15:0]}}, mask = a[1] ? 4'b1100 : 4'b0011; misaligned if a[0]=1.
  - SW: data = rs2, mask = 4'b1111; misaligned if a!=0.
  - funct3 not in {000,001,010}: reported through misaligned_out.
- dm_addr_out clears bits [1:0] and is otherwise unmodified; no wrap handling is needed.

Optional Feature:
- Macro MSRV32_STORE_TIMEOUT_EN.
- Defined: a counter clears on entry to REQ and increments each REQ cycle without ack. If the count reaches TIMEOUT_CYCLES-1 with no ack, the next edge goes to IDLE with dm_wr_req_out=0, busy_out=0, timeout_out pulsed and no done_out. Ack arriving in the same cycle as the limit wins: completion, not timeout.
- Undefined: no counter; REQ waits indefinitely; timeout_out tied 0.

Decomposition:
- Package msrv32_pkg holds:
  - store funct3 constants (SB, SH, SW)
  - state enum (IDLE, REQ)
  - lane-mask constants
- Sub-module msrv32_store_lane_gen: combinational generation of data, mask and misaligned from funct3, addr[1:0] and rs2. The FSM/handshake stays in msrv32_store_unit.

Test Plan:
- SW, addr 0x0000_1000, rs2 0xDEAD_BEEF, ack 2 cycles after req -> addr 0x1000, data 0xDEADBEEF, mask 1111; busy for 3 cycles; done one pulse; dm_wr_req_out low after ack.
- SB, addr 0x0000_2003, rs2 0x0000_00A5 -> addr 0x2000, data 0xA5A5A5A5, mask 1000; SH, addr 0x2002, rs2 0x1234 -> data 0x12341234, mask 1100.
- SH at addr 0x3001; SW at 0x3002; funct3 011 -> misaligned_out pulses each time; dm_wr_req_out stays 0; busy_out stays 0.
- store_req_in asserted again while in REQ with different data -> outputs hold the first transaction; only one done_out.
- Reset asserted 1 cycle into REQ -> next edge: all outputs 0, state IDLE; a later ack is ignored.
- With MSRV32_STORE_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never arrives -> timeout_out pulses after 4 REQ cycles; no done_out. Ack on the 4th cycle -> done_out, no timeout.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared constants and types for the msrv32 store path: funct3 encodings,
// FSM state and byte-lane mask constants.
package msrv32_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [3:0] MASK_BYTE    = 4'b0001;
  localparam logic [3:0] MASK_HALF_LO = 4'b0011;
  localparam logic [3:0] MASK_HALF_HI = 4'b1100;
  localparam logic [3:0] MASK_WORD    = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } store_state_e;

endpackage

// File: rtl/msrv32_store_lane_gen.sv
// Combinational lane steering for RV32I stores: replicates rs2 across byte
// lanes, builds the byte enable and flags misaligned or illegal widths.
module msrv32_store_lane_gen
  import msrv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lsb,
  input  logic [31:0] rs2,
  output logic [31:0] data,
  output logic [3:0]  mask,
  output logic        misaligned
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    data       = '0;
    mask       = '0;
    misaligned = 1'b0;
    case (funct3)
      F3_SB: begin
        data = {4{rs2[7:0]}};
        mask = MASK_BYTE << addr_lsb;
      end
      F3_SH: begin
        data       = {2{rs2[15:0]}};
        mask       = addr_lsb[1] ? MASK_HALF_HI : MASK_HALF_LO;
        misaligned = addr_lsb[0];
      end
      F3_SW: begin
        data       = rs2;
        mask       = MASK_WORD;
        misaligned = |addr_lsb;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/msrv32_store_unit.sv
// RV32I store unit: lane-aligns a store and runs a req/ack handshake with data
// memory. Define MSRV32_STORE_TIMEOUT_EN to abort a store that is never acked.
module msrv32_store_unit
  import msrv32_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic              store_req_in,
  input  logic [2:0]        funct3_in,
  input  logic [ADDR_W-1:0] iadder_in,
  input  logic [DATA_W-1:0] rs2_in,
  input  logic              dm_ack_in,
  output logic              dm_wr_req_out,
  output logic [ADDR_W-1:0] dm_addr_out,
  output logic [DATA_W-1:0] dm_data_out,
  output logic [3:0]        dm_wr_mask_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              misaligned_out,
  output logic              timeout_out
);

  store_state_e state;

  logic [31:0] lane_data;
  logic [3:0]  lane_mask;
  logic        lane_misaligned;

  msrv32_store_lane_gen u_lane_gen (
    .funct3     (funct3_in),
    .addr_lsb   (iadder_in[1:0]),
    .rs2        (rs2_in),
    .data       (lane_data),
    .mask       (lane_mask),
    .misaligned (lane_misaligned)
  );

`ifdef MSRV32_STORE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign timeout_out = 1'b0;
`endif

  // NOTE: state and registered outputs use non-blocking assignments so every
  // read in this block sees the pre-edge value.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state          <= IDLE;
      dm_wr_req_out  <= 1'b0;
      dm_addr_out    <= '0;
      dm_data_out    <= '0;
      dm_wr_mask_out <= '0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      misaligned_out <= 1'b0;
`ifdef MSRV32_STORE_TIMEOUT_EN
      timeout_out    <= 1'b0;
      wait_cnt       <= '0;
`endif
    end else begin
      done_out       <= 1'b0;
      misaligned_out <= 1'b0;
`ifdef MSRV32_STORE_TIMEOUT_EN
      timeout_out    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (store_req_in) begin
            if (lane_misaligned) begin
              misaligned_out <= 1'b1;
            end else begin
              state          <= REQ;
              dm_wr_req_out  <= 1'b1;
              busy_out       <= 1'b1;
              dm_addr_out    <= {iadder_in[ADDR_W-1:2], 2'b00};
              dm_data_out    <= DATA_W'(lane_data);
              dm_wr_mask_out <= lane_mask;
`ifdef MSRV32_STORE_TIMEOUT_EN
              wait_cnt       <= '0;
`endif
            end
          end
        end
        REQ: begin
          // Ack is checked first so an ack on the final allowed cycle completes.
          if (dm_ack_in) begin
            state         <= IDLE;
            dm_wr_req_out <= 1'b0;
            busy_out      <= 1'b0;
            done_out      <= 1'b1;
`ifdef MSRV32_STORE_TIMEOUT_EN
          end else if (wait_cnt == CNT_LAST) begin
            state         <= IDLE;
            dm_wr_req_out <= 1'b0;
            busy_out      <= 1'b0;
            timeout_out   <= 1'b1;
          end else begin
            wait_cnt      <= wait_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_store_unit.sv
// Self-checking bench for msrv32_store_unit: directed cases plus randomized
// stores checked against a byte-lane reference model.
module tb_msrv32_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        store_req;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] rs2;
  logic        ack;
  logic        dm_wr_req;
  logic [31:0] dm_addr;
  logic [31:0] dm_data;
  logic [3:0]  dm_mask;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  msrv32_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .store_req_in         (store_req),
    .funct3_in            (f3),
    .iadder_in            (addr),
    .rs2_in               (rs2),
    .dm_ack_in            (ack),
    .dm_wr_req_out        (dm_wr_req),
    .dm_addr_out          (dm_addr),
    .dm_data_out          (dm_data),
    .dm_wr_mask_out       (dm_mask),
    .busy_out             (busy),
    .done_out             (done),
    .misaligned_out       (misaligned),
    .timeout_out          (timeout)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference: a store of `size` bytes at byte offset `off` occupies lanes
  // off..off+size-1; lane i carries source byte (i mod size).
  function automatic void model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] r,
                                output logic bad, output logic [31:0] d, output logic [3:0] m);
    int size;
    int off;
    off = int'(a[1:0]);
    case (f)
      3'd0:    size = 1;
      3'd1:    size = 2;
      3'd2:    size = 4;
      default: size = 0;
    endcase
    d = '0;
    m = '0;
    if (size == 0) begin
      bad = 1'b1;
    end else begin
      bad = (off % size) != 0;
      for (int i = 0; i < 4; i++) begin
        d[8*i +: 8] = r[8*(i % size) +: 8];
        m[i]        = (i >= off) && (i < off + size);
      end
    end
  endfunction

  // Called at a falling edge; ends at the falling edge where done_out (or
  // misaligned_out) is expected high, so consecutive calls run back-to-back.
  task automatic do_store(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] r, input int delay, input bit poke);
    logic        bad;
    logic [31:0] exp_d;
    logic [3:0]  exp_m;
    int          busy_cycles;
    model(f, a, r, bad, exp_d, exp_m);
    store_req = 1'b1;
    f3        = f;
    addr      = a;
    rs2       = r;
    @(negedge clk);
    store_req = 1'b0;
    if (bad) begin
      check({tag, " misaligned"}, misaligned, 1'b1);
      check({tag, " no_req"}, dm_wr_req, 1'b0);
      check({tag, " no_busy"}, busy, 1'b0);
      return;
    end
    check({tag, " req"}, dm_wr_req, 1'b1);
    check({tag, " busy"}, busy, 1'b1);
    check({tag, " addr"}, dm_addr, {a[31:2], 2'b00});
    check({tag, " data"}, dm_data, exp_d);
    check({tag, " mask"}, dm_mask, exp_m);
    check({tag, " no_done"}, done, 1'b0);
    check({tag, " no_mis"}, misaligned, 1'b0);
    busy_cycles = 1;
    for (int k = 0; k < delay; k++) begin
      if (poke && k == 0) begin
        store_req = 1'b1;
        f3        = 3'b010;
        addr      = ~a & 32'hFFFF_FFFC;
        rs2       = ~r;
      end
      @(negedge clk);
      store_req = 1'b0;
      check({tag, " hold_addr"}, dm_addr, {a[31:2], 2'b00});
      check({tag, " hold_data"}, dm_data, exp_d);
      check({tag, " hold_mask"}, dm_mask, exp_m);
      check({tag, " hold_done"}, done, 1'b0);
      if (busy) busy_cycles++;
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check({tag, " done"}, done, 1'b1);
    check({tag, " req_low"}, dm_wr_req, 1'b0);
    check({tag, " busy_low"}, busy, 1'b0);
    check({tag, " no_timeout"}, timeout, 1'b0);
    check({tag, " busy_cycles"}, busy_cycles, delay + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra;
    rst       = 1'b1;
    store_req = 1'b0;
    f3        = '0;
    addr      = '0;
    rs2       = '0;
    ack       = 1'b0;
    repeat (2) @(negedge clk);
    check("rst req", dm_wr_req, 1'b0);
    check("rst addr", dm_addr, 32'h0);
    check("rst data", dm_data, 32'h0);
    check("rst mask", dm_mask, 4'h0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst mis", misaligned, 1'b0);
    check("rst timeout", timeout, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("idle_ack req", dm_wr_req, 1'b0);
    check("idle_ack busy", busy, 1'b0);
    check("idle_ack done", done, 1'b0);

    do_store("sw", 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 2, 1'b0);
    do_store("sb", 3'b000, 32'h0000_2003, 32'h0000_00A5, 0, 1'b0);
    do_store("sh", 3'b001, 32'h0000_2002, 32'h0000_1234, 1, 1'b0);
    do_store("sh_mis", 3'b001, 32'h0000_3001, 32'h0000_5555, 0, 1'b0);
    do_store("sw_mis", 3'b010, 32'h0000_3002, 32'h0000_5555, 0, 1'b0);
    do_store("f3_011", 3'b011, 32'h0000_3000, 32'h0000_5555, 0, 1'b0);
    @(negedge clk);
    check("mis_pulse_end", misaligned, 1'b0);
    check("mis_no_req", dm_wr_req, 1'b0);

    do_store("poke", 3'b010, 32'h0000_4000, 32'h1122_3344, 2, 1'b1);
    @(negedge clk);
    check("poke single_done", done, 1'b0);
    check("poke idle", busy, 1'b0);

    // Reset one cycle into REQ, then a stale ack must be ignored.
    store_req = 1'b1;
    f3        = 3'b000;
    addr      = 32'h0000_5001;
    rs2       = 32'h0000_0077;
    @(negedge clk);
    store_req = 1'b0;
    check("rstmid req_before", dm_wr_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid req", dm_wr_req, 1'b0);
    check("rstmid busy", busy, 1'b0);
    check("rstmid addr", dm_addr, 32'h0);
    check("rstmid data", dm_data, 32'h0);
    check("rstmid mask", dm_mask, 4'h0);
    check("rstmid done", done, 1'b0);
    rst = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("rstmid late_ack done", done, 1'b0);
    check("rstmid late_ack req", dm_wr_req, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rf = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      ra = $urandom;
      do_store("rand", rf, ra, $urandom, int'($urandom_range(0, 3)), 1'b0);
    end
    @(negedge clk);

`ifdef MSRV32_STORE_TIMEOUT_EN
    begin
      int req_cycles;
      bit seen;
      store_req = 1'b1;
      f3        = 3'b010;
      addr      = 32'h0000_6000;
      rs2       = 32'hCAFE_F00D;
      @(negedge clk);
      store_req  = 1'b0;
      req_cycles = 0;
      seen       = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        if (timeout) begin
          seen = 1'b1;
        end else begin
          if (dm_wr_req) req_cycles++;
          @(negedge clk);
        end
      end
      check("to seen", seen, 1'b1);
      check("to req_cycles", req_cycles, 4);
      check("to no_done", done, 1'b0);
      check("to req_low", dm_wr_req, 1'b0);
      check("to busy_low", busy, 1'b0);
      @(negedge clk);
      check("to pulse_end", timeout, 1'b0);
      do_store("to_ack_last", 3'b010, 32'h0000_7000, 32'h0BAD_CAFE, 3, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
